kilit_denetleyici: RTL and testbench

Sequential controller that drives the dual-lock datapath (two lock evaluators whose outputs are ANDed) from a serial keypad-style step interface. It collects four step entries (lock 1 right, lock 1 left, lock 0 right, lock 0 left) and evaluates them on submit against a programmable 12-bit password. It holds the locks open for a fixed window and enforces a wrong-attempt limit with a timed lockout. It sits between the user input logic and the lock datapath and owns all state the combinational locks lack.

---
 rtl/kilit_denetleyici_if.sv | 30 +++
 rtl/kilit_denetleyici.sv | 164 ++++++++++++++++
 tb/tb_kilit_denetleyici.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kilit_denetleyici_if.sv
// kilit_denetleyici_if
// Step entry / password load / status bundle between the user input logic
// and the dual-lock controller.
//   master : user side. Drives step entries, submit and password load, and
//            reads the controller status.
//   slave  : controller side. Mirror image of master.
`timescale 1ns/1ps
interface kilit_denetleyici_if;
  logic        adim_gecerli;
  logic        adim_yon;      // 0 = sag, 1 = sol
  logic [2:0]  adim_deger;
  logic        onayla;
  logic        sifre_yaz;
  logic [11:0] sifre_veri;    // [11:6] lock 1, [5:0] lock 0
  logic        hazir;
  logic        kilitler_acik;
  logic        hata;
  logic        kilitli;
  logic [2:0]  kalan_hak;

  modport master (
    output adim_gecerli, adim_yon, adim_deger, onayla, sifre_yaz, sifre_veri,
    input  hazir, kilitler_acik, hata, kilitli, kalan_hak
  );

  modport slave (
    input  adim_gecerli, adim_yon, adim_deger, onayla, sifre_yaz, sifre_veri,
    output hazir, kilitler_acik, hata, kilitli, kalan_hak
  );
endinterface

// File: rtl/kilit_denetleyici.sv
// kilit_denetleyici
// Sequencing controller for the dual-lock datapath. Collects four step
// entries (lock 1 sag/sol, lock 0 sag/sol), evaluates them on submit against
// a programmable 12-bit password, holds the locks open for a fixed window and
// enforces a wrong-attempt limit with a timed lockout.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : kilit_denetleyici_if.slave (steps, submit, password load, status)
//
// state       | meaning
// ------------+----------------------------------------------------------
// BOSTA       | idle, accepting steps / submit / password load
// DEGERLENDIR | one-cycle evaluation of the frozen step registers
// ACIK        | locks open, down-counter running
// KILITLI     | lockout after too many failures, down-counter running
`timescale 1ns/1ps
module kilit_denetleyici #(
  parameter int DENEME_SAYISI    = 3,
  parameter int ACIK_SURESI      = 8,
  parameter int KILITLEME_SURESI = 16
) (
  input logic             clk,
  input logic             rst_n,
  kilit_denetleyici_if.slave bus
);

  localparam int SAYAC_MAX = (ACIK_SURESI > KILITLEME_SURESI) ? ACIK_SURESI : KILITLEME_SURESI;
  localparam int SAYAC_W   = $clog2(SAYAC_MAX + 1);

  typedef enum logic [1:0] {
    BOSTA       = 2'd0,
    DEGERLENDIR = 2'd1,
    ACIK        = 2'd2,
    KILITLI     = 2'd3
  } durum_t;

  durum_t             durum;
  logic [2:0]         indeks;
  logic [2:0]         sag1, sag0;
  logic [1:0]         sol1, sol0;
  logic [11:0]        sifre;
  logic [SAYAC_W-1:0] sayac;
  logic               hazir_q, acik_q, hata_q, kilitli_q;
  logic [2:0]         kalan_q;

  // 3-bit subtraction wraps, which gives the mod-8 reduction for free.
  logic [2:0] fark1, fark0;
  logic [5:0] konum1, konum0;
  logic       eslesme;

  assign fark1   = sag1 - {sol1, 1'b0};
  assign fark0   = sag0 - {sol0, 1'b0};
  assign konum1  = {3'b000, fark1} * 6'd5;
  assign konum0  = {3'b000, fark0} * 6'd5;
  // An incomplete entry never opens, even if stale slot contents would match.
  assign eslesme = (indeks == 3'd4) && (konum1 == sifre[11:6]) && (konum0 == sifre[5:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum     <= BOSTA;
      indeks    <= 3'd0;
      sag1      <= 3'd0;
      sol1      <= 2'd0;
      sag0      <= 3'd0;
      sol0      <= 2'd0;
      sifre     <= 12'h000;
      sayac     <= '0;
      hazir_q   <= 1'b1;
      acik_q    <= 1'b0;
      hata_q    <= 1'b0;
      kilitli_q <= 1'b0;
      kalan_q   <= 3'(DENEME_SAYISI);
    end else begin
      hata_q <= 1'b0;
      case (durum)
        BOSTA: begin
          if (bus.onayla) begin
            durum   <= DEGERLENDIR;
            hazir_q <= 1'b0;
          end else if (bus.adim_gecerli) begin
            if (indeks != 3'd4) begin
              // Slots alternate sag, sol, sag, sol, so the expected
              // direction is simply the index LSB.
              if (bus.adim_yon == indeks[0]) begin
                case (indeks[1:0])
                  2'd0:    sag1 <= bus.adim_deger;
                  2'd1:    sol1 <= bus.adim_deger[1:0];
                  2'd2:    sag0 <= bus.adim_deger;
                  default: sol0 <= bus.adim_deger[1:0];
                endcase
                indeks  <= indeks + 3'd1;
                hazir_q <= (indeks != 3'd3);
              end else begin
                indeks  <= 3'd0;
                hata_q  <= 1'b1;
                hazir_q <= 1'b1;
              end
            end
          end else if (bus.sifre_yaz && (indeks == 3'd0)) begin
            sifre <= bus.sifre_veri;
          end
        end

        DEGERLENDIR: begin
          indeks <= 3'd0;
          if (eslesme) begin
            durum   <= ACIK;
            acik_q  <= 1'b1;
            kalan_q <= 3'(DENEME_SAYISI);
            sayac   <= SAYAC_W'(ACIK_SURESI - 1);
          end else if (kalan_q > 3'd1) begin
            durum   <= BOSTA;
            hata_q  <= 1'b1;
            hazir_q <= 1'b1;
            kalan_q <= kalan_q - 3'd1;
          end else begin
            durum     <= KILITLI;
            hata_q    <= 1'b1;
            kilitli_q <= 1'b1;
            kalan_q   <= 3'd0;
            sayac     <= SAYAC_W'(KILITLEME_SURESI - 1);
          end
        end

        ACIK: begin
          if (sayac == '0) begin
            durum   <= BOSTA;
            acik_q  <= 1'b0;
            hazir_q <= 1'b1;
          end else begin
            sayac <= sayac - SAYAC_W'(1);
          end
        end

        KILITLI: begin
          if (sayac == '0) begin
            durum     <= BOSTA;
            kilitli_q <= 1'b0;
            hazir_q   <= 1'b1;
            kalan_q   <= 3'(DENEME_SAYISI);
          end else begin
            sayac <= sayac - SAYAC_W'(1);
          end
        end

        default: begin
          durum     <= BOSTA;
          indeks    <= 3'd0;
          hazir_q   <= 1'b1;
          acik_q    <= 1'b0;
          kilitli_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hazir         = hazir_q;
  assign bus.kilitler_acik = acik_q;
  assign bus.hata          = hata_q;
  assign bus.kilitli       = kilitli_q;
  assign bus.kalan_hak     = kalan_q;

endmodule

// File: tb/tb_kilit_denetleyici.sv
// tb_kilit_denetleyici
// Directed bench for kilit_denetleyici with default parameters (3 attempts,
// 8-cycle open window, 16-cycle lockout). Inputs change on the falling edge;
// outputs are read on the falling edge after the rising edge that acted.
`timescale 1ns/1ps
module tb_kilit_denetleyici;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  kilit_denetleyici_if bus ();

  kilit_denetleyici dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adim(input logic yon, input logic [2:0] d);
    @(negedge clk);
    bus.adim_gecerli = 1'b1;
    bus.adim_yon     = yon;
    bus.adim_deger   = d;
    @(negedge clk);
    bus.adim_gecerli = 1'b0;
  endtask

  // Returns in cycle n+1 (onayla high in cycle n).
  task automatic onay();
    @(negedge clk);
    bus.onayla = 1'b1;
    @(negedge clk);
    bus.onayla = 1'b0;
  endtask

  task automatic dogru_adimlar();
    adim(1'b0, 3'd3);
    adim(1'b1, 3'd1);
    adim(1'b0, 3'd7);
    adim(1'b1, 3'd2);
  endtask

  task automatic yanlis_adimlar();
    adim(1'b0, 3'd0);
    adim(1'b1, 3'd0);
    adim(1'b0, 3'd0);
    adim(1'b1, 3'd0);
  endtask

  // Called in cycle n+1 after onay.
  task automatic acik_kontrol(input string tag);
    int sayi;
    chk({tag, "_eval_hazir"}, bus.hazir, 1'b0);
    chk({tag, "_eval_acik"}, bus.kilitler_acik, 1'b0);
    @(negedge clk);
    chk({tag, "_first_acik"}, bus.kilitler_acik, 1'b1);
    chk({tag, "_kalan"}, bus.kalan_hak, 3'd3);
    chk({tag, "_open_hazir"}, bus.hazir, 1'b0);
    sayi = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.kilitler_acik) sayi++;
    end
    chk({tag, "_acik_cycles"}, sayi, 8);
    chk({tag, "_hazir_after"}, bus.hazir, 1'b1);
  endtask

  // Called in cycle n+1 after onay, for a non-locking failure.
  task automatic hata_kontrol(input string tag, input logic [2:0] exp_kalan);
    chk({tag, "_eval_hazir"}, bus.hazir, 1'b0);
    chk({tag, "_eval_hata"}, bus.hata, 1'b0);
    @(negedge clk);
    chk({tag, "_hata"}, bus.hata, 1'b1);
    chk({tag, "_kalan"}, bus.kalan_hak, exp_kalan);
    chk({tag, "_hazir"}, bus.hazir, 1'b1);
    chk({tag, "_acik"}, bus.kilitler_acik, 1'b0);
    @(negedge clk);
    chk({tag, "_hata_gone"}, bus.hata, 1'b0);
  endtask

  initial begin
    int sayi;
    int hata_sayi;
    bus.adim_gecerli = 1'b0;
    bus.adim_yon     = 1'b0;
    bus.adim_deger   = 3'd0;
    bus.onayla       = 1'b0;
    bus.sifre_yaz    = 1'b0;
    bus.sifre_veri   = 12'h000;

    repeat (2) @(negedge clk);
    chk("rst_hazir", bus.hazir, 1'b1);
    chk("rst_acik", bus.kilitler_acik, 1'b0);
    chk("rst_hata", bus.hata, 1'b0);
    chk("rst_kilitli", bus.kilitli, 1'b0);
    chk("rst_kalan", bus.kalan_hak, 3'd3);
    rst_n = 1'b1;

    // Password 12'h14F: lock 1 = 5, lock 0 = 15.
    @(negedge clk);
    bus.sifre_yaz  = 1'b1;
    bus.sifre_veri = 12'h14F;
    @(negedge clk);
    bus.sifre_yaz  = 1'b0;
    bus.sifre_veri = 12'h000;

    // Open, with a fifth step (wrong direction) that must be ignored.
    adim(1'b0, 3'd3);
    chk("step1_hazir", bus.hazir, 1'b1);
    adim(1'b1, 3'd1);
    adim(1'b0, 3'd7);
    adim(1'b1, 3'd2);
    chk("full_hazir", bus.hazir, 1'b0);
    adim(1'b0, 3'd0);
    chk("extra_hata", bus.hata, 1'b0);
    chk("extra_hazir", bus.hazir, 1'b0);
    onay();
    acik_kontrol("open");

    // Wrong code.
    yanlis_adimlar();
    onay();
    hata_kontrol("wrong", 3'd2);

    // Sol as first entry: hata next cycle, no attempt consumed.
    adim(1'b1, 3'd1);
    chk("seq_hata", bus.hata, 1'b1);
    chk("seq_kalan", bus.kalan_hak, 3'd2);
    chk("seq_hazir", bus.hazir, 1'b1);
    @(negedge clk);
    chk("seq_hata_gone", bus.hata, 1'b0);
    // Mismatch at index 1 must restart entry from slot 0.
    adim(1'b0, 3'd3);
    adim(1'b0, 3'd1);
    chk("seq2_hata", bus.hata, 1'b1);
    dogru_adimlar();
    onay();
    acik_kontrol("seq_open");

    // Submit after 2 steps: failure even though stale slots would match.
    adim(1'b0, 3'd3);
    adim(1'b1, 3'd1);
    onay();
    hata_kontrol("short", 3'd2);

    // onayla with a simultaneous step: step not stored, attempt incomplete.
    adim(1'b0, 3'd3);
    adim(1'b1, 3'd1);
    adim(1'b0, 3'd7);
    @(negedge clk);
    bus.onayla       = 1'b1;
    bus.adim_gecerli = 1'b1;
    bus.adim_yon     = 1'b1;
    bus.adim_deger   = 3'd2;
    @(negedge clk);
    bus.onayla       = 1'b0;
    bus.adim_gecerli = 1'b0;
    hata_kontrol("prio", 3'd1);

    // sifre_yaz at index 2 ignored: old password still opens.
    adim(1'b0, 3'd3);
    adim(1'b1, 3'd1);
    @(negedge clk);
    bus.sifre_yaz  = 1'b1;
    bus.sifre_veri = 12'h000;
    @(negedge clk);
    bus.sifre_yaz  = 1'b0;
    adim(1'b0, 3'd7);
    adim(1'b1, 3'd2);
    onay();
    acik_kontrol("pw_ign");

    // Lockout after three wrong attempts.
    yanlis_adimlar();
    onay();
    hata_kontrol("lk1", 3'd2);
    yanlis_adimlar();
    onay();
    hata_kontrol("lk2", 3'd1);
    yanlis_adimlar();
    onay();
    chk("lk3_eval_kilitli", bus.kilitli, 1'b0);
    @(negedge clk);
    chk("lk3_hata", bus.hata, 1'b1);
    chk("lk3_kilitli", bus.kilitli, 1'b1);
    chk("lk3_kalan", bus.kalan_hak, 3'd0);
    chk("lk3_hazir", bus.hazir, 1'b0);
    sayi = 1;
    hata_sayi = 0;
    for (int i = 0; i < 19; i++) begin
      bus.adim_gecerli = (i < 12);
      bus.adim_yon     = 1'b0;
      bus.adim_deger   = 3'd3;
      bus.onayla       = (i < 12) && i[0];
      @(negedge clk);
      if (bus.kilitli) sayi++;
      if (bus.hata) hata_sayi++;
    end
    bus.adim_gecerli = 1'b0;
    bus.onayla       = 1'b0;
    chk("lk_cycles", sayi, 16);
    chk("lk_no_hata", hata_sayi, 0);
    chk("lk_after_kalan", bus.kalan_hak, 3'd3);
    chk("lk_after_hazir", bus.hazir, 1'b1);
    chk("lk_after_acik", bus.kilitler_acik, 1'b0);
    dogru_adimlar();
    onay();
    acik_kontrol("lk_open");

    // Reset during the open window.
    dogru_adimlar();
    onay();
    @(negedge clk);
    chk("rst_mid_acik_before", bus.kilitler_acik, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_acik", bus.kilitler_acik, 1'b0);
    chk("rst_mid_hazir", bus.hazir, 1'b1);
    chk("rst_mid_kalan", bus.kalan_hak, 3'd3);
    @(negedge clk);
    rst_n = 1'b1;
    yanlis_adimlar();
    onay();
    acik_kontrol("rst_pw0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
